// File: rtl/read_port_arbiter.sv
// read_port_arbiter
// Shares one fixed-latency synchronous read port among NUM_REQ requesters.
// A round-robin pointer picks one requester per cycle. A tag pipeline matched
// to the memory latency routes each returned word back to the requester that
// issued the read. A return that disagrees with the tag pipeline sets a
// sticky error flag and is dropped.
// Optional feature: define READ_ARB_BURST_LOCK_EN to add the reqLock input and
// a ROTATE/LOCKED FSM that lets one requester hold the port for up to
// MAX_BURST consecutive grants.

module read_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr,
`ifdef READ_ARB_BURST_LOCK_EN
    input  logic [NUM_REQ-1:0]            reqLock,
`endif
    output logic [NUM_REQ-1:0]            reqReady,
    output logic                          memReadEnable,
    output logic [ADDR_WIDTH-1:0]         memAddr,
    input  logic                          memReadValid,
    input  logic [DATA_WIDTH-1:0]         memReadData,
    output logic [NUM_REQ-1:0]            rspValid,
    output logic [DATA_WIDTH-1:0]         rspData,
    output logic                          errorFlag
);

    localparam int IDX_W = $clog2(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    // Reject parameter values the design is not built for.
    if (NUM_REQ < 2 || NUM_REQ > 8 || READ_LATENCY < 1 || READ_LATENCY > 4 || MAX_BURST < 1) begin : g_param_check
        $error("read_port_arbiter: parameter out of supported range");
    end

    idx_t last_q;
    logic rr_any;
    idx_t rr_idx;
    logic grant_any;
    idx_t grant_idx;

    // Round-robin search: first valid requester starting one past the last grant.
    always_comb begin
        int   j;
        idx_t cand;
        // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        rr_any = 1'b0;
        rr_idx = last_q;
        j      = 0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(last_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = idx_t'(j);
            if (!rr_any && reqValid[cand]) begin
                rr_any = 1'b1;
                rr_idx = cand;
            end
        end
    end

`ifdef READ_ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    typedef enum logic {ROTATE, LOCKED} lock_state_t;

    lock_state_t      state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             hold;

    // Lock FSM next state: the locked requester (always last_q) keeps the
    // port while it still wants it and the burst budget is not spent;
    // otherwise arbitrate round-robin and possibly lock onto the new winner.
    always_comb begin
        hold      = (state_q == LOCKED) && reqValid[last_q] && reqLock[last_q]
                    && (burst_q < CNT_W'(MAX_BURST));
        state_d   = state_q;
        burst_d   = burst_q;
        grant_any = 1'b0;
        grant_idx = rr_idx;
        if (hold) begin
            grant_any = 1'b1;
            grant_idx = last_q;
            burst_d   = burst_q + 1'b1;
        end else begin
            grant_any = rr_any;
            grant_idx = rr_idx;
            state_d   = ROTATE;
            burst_d   = '0;
            if (rr_any && reqLock[rr_idx]) begin
                state_d = LOCKED;
                burst_d = CNT_W'(1);
            end
        end
        // No grants while reset is asserted.
        if (!reset) grant_any = 1'b0;
    end

    // Lock FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ROTATE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end
`else
    // Pure round-robin grant, suppressed while reset is asserted (active low).
    always_comb begin
        grant_any = rr_any & reset;
        grant_idx = rr_idx;
    end
`endif

    // Drive the one-hot grant and the memory read port from the winner.
    always_comb begin
        reqReady      = '0;
        memAddr       = '0;
        memReadEnable = grant_any;
        if (grant_any) begin
            reqReady[grant_idx] = 1'b1;
            memAddr             = reqAddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Priority pointer: remembers the most recent grant.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values regardless of block order.
        if (!reset)         last_q <= idx_t'(NUM_REQ - 1);
        else if (grant_any) last_q <= grant_idx;
    end

    logic tag_valid_q [READ_LATENCY];
    idx_t tag_idx_q   [READ_LATENCY];
    logic head_valid;
    idx_t head_idx;

    assign head_valid = tag_valid_q[READ_LATENCY-1];
    assign head_idx   = tag_idx_q[READ_LATENCY-1];

    // Tag pipeline valid bits: cleared on reset so in-flight reads are forgotten.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < READ_LATENCY; s++) tag_valid_q[s] <= 1'b0;
        end else begin
            tag_valid_q[0] <= grant_any;
            for (int s = 1; s < READ_LATENCY; s++) tag_valid_q[s] <= tag_valid_q[s-1];
        end
    end

    // Tag pipeline indices: shift alongside the valid bits.
    always_ff @(posedge clock) begin
        // NOTE: index stages carry no reset; they are ignored whenever their valid bit is low.
        tag_idx_q[0] <= grant_idx;
        for (int s = 1; s < READ_LATENCY; s++) tag_idx_q[s] <= tag_idx_q[s-1];
    end

    // Response register and sticky mismatch detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rspValid  <= '0;
            rspData   <= '0;
            errorFlag <= 1'b0;
        end else begin
            rspValid <= '0;
            if (head_valid && memReadValid) begin
                rspValid[head_idx] <= 1'b1;
                rspData            <= memReadData;
            end
            if (head_valid != memReadValid) errorFlag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_read_port_arbiter.sv
// tb_read_port_arbiter
// Randomized and directed stimulus for read_port_arbiter with a behavioural
// memory model (data derived from address) and a reference arbiter model.
// Expected responses go into a queue; a monitor on the falling edge pops and
// compares them. Built with or without READ_ARB_BURST_LOCK_EN.

`timescale 1ns/1ps

module tb_read_port_arbiter;

    localparam int N    = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int L    = 3;
    localparam int MAXB = 8;
`ifdef READ_ARB_BURST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    reqValid;
    logic [N*AW-1:0] reqAddr;
    logic [N-1:0]    lk_drv;
    logic [N-1:0]    reqReady;
    logic            memReadEnable;
    logic [AW-1:0]   memAddr;
    logic            memReadValid;
    logic [DW-1:0]   memReadData;
    logic [N-1:0]    rspValid;
    logic [DW-1:0]   rspData;
    logic            errorFlag;

    always #5 clock = ~clock;

    read_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .READ_LATENCY(L), .MAX_BURST(MAXB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .reqValid(reqValid),
        .reqAddr(reqAddr),
`ifdef READ_ARB_BURST_LOCK_EN
        .reqLock(lk_drv),
`endif
        .reqReady(reqReady),
        .memReadEnable(memReadEnable),
        .memAddr(memAddr),
        .memReadValid(memReadValid),
        .memReadData(memReadData),
        .rspValid(rspValid),
        .rspData(rspData),
        .errorFlag(errorFlag)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    bit            mon_en = 1'b0;
    bit            chk_err = 1'b0;

    // reference arbiter state
    int            m_last;
    int            m_lock_idx;
    int            m_burst;
    bit            err_model;
    logic [DW-1:0] hold_data;

    // memory model state
    logic          mem_v [L];
    logic [AW-1:0] mem_a [L];
    logic          samp_en;
    logic [AW-1:0] samp_addr;
    bit            mismatch_prev;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (DW'(a) << 16) ^ DW'(a) ^ 32'hC3A5_0000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: advance models over the edge, drive inputs, check the
    // combinational grant, and queue the response the reference predicts.
    task automatic step(input logic rst_val, input logic [N-1:0] v,
                        input logic [N*AW-1:0] a, input logic [N-1:0] lk, input bit inject);
        int            g;
        int            j;
        logic [AW-1:0] g_addr;
        logic [N-1:0]  lk_eff;
        logic [N-1:0]  exp_ready;
        logic          exp_en;
        bit            head_due;

        @(posedge clock);
        #1;
        if (!reset) begin
            for (int s = 0; s < L; s++) begin
                mem_v[s] = 1'b0;
                mem_a[s] = '0;
            end
            err_model = 1'b0;
            hold_data = '0;
        end else begin
            for (int s = L - 1; s > 0; s--) begin
                mem_v[s] = mem_v[s-1];
                mem_a[s] = mem_a[s-1];
            end
            mem_v[0] = samp_en;
            mem_a[0] = samp_addr;
            if (mismatch_prev) err_model = 1'b1;
        end

        reset        = rst_val;
        reqValid     = v;
        reqAddr      = a;
        lk_drv       = lk;
        memReadValid = mem_v[L-1] | inject;
        memReadData  = mem_word(mem_a[L-1]);
        #1;

        lk_eff = LOCK_EN ? lk : '0;
        g = -1;
        if (rst_val) begin
            if (m_lock_idx >= 0 && v[m_lock_idx] && lk_eff[m_lock_idx] && m_burst < MAXB) begin
                g = m_lock_idx;
                m_burst++;
            end else begin
                m_lock_idx = -1;
                m_burst    = 0;
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (g < 0 && v[j]) g = j;
                end
                if (g >= 0 && lk_eff[g]) begin
                    m_lock_idx = g;
                    m_burst    = 1;
                end
            end
        end

        exp_ready = '0;
        exp_en    = 1'b0;
        g_addr    = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_en       = 1'b1;
            g_addr       = a[g*AW +: AW];
        end
        check("grant", {reqReady, memReadEnable, memAddr}, {exp_ready, exp_en, g_addr});
        if (chk_err) check("error_flag", errorFlag, err_model);

        head_due = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].due == cyc + 1) head_due = 1'b1;
        mismatch_prev = (memReadValid != head_due);

        samp_en   = memReadEnable;
        samp_addr = memAddr;

        if (g >= 0) begin
            exp_q.push_back('{idx: g, data: mem_word(g_addr), due: cyc + L + 1});
            m_last = g;
        end

        if (!rst_val) begin
            m_last        = N - 1;
            m_lock_idx    = -1;
            m_burst       = 0;
            mismatch_prev = 1'b0;
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].due > cyc) exp_q.delete(i);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, 1'b0);
    endtask

    function automatic logic [N*AW-1:0] rand_addrs();
        logic [N*AW-1:0] r;
        for (int i = 0; i < N; i++) r[i*AW +: AW] = AW'($urandom);
        return r;
    endfunction

    // Monitor: compares every cycle's response against the queue head.
    always @(negedge clock) begin
        exp_t         e;
        logic [N-1:0] oh;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_missing: got no response, expected index %0d due cycle %0d (now %0d)",
                         exp_q[0].idx, exp_q[0].due, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e      = exp_q.pop_front();
                oh     = '0;
                oh[e.idx] = 1'b1;
                check("rsp_valid", rspValid, oh);
                check("rsp_data", rspData, e.data);
                hold_data = e.data;
            end else begin
                check("rsp_idle", {rspValid, rspData}, {N'(0), hold_data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N*AW-1:0] a;
        logic [N-1:0]    lk;

        reset = 1'b0; reqValid = '0; reqAddr = '0; lk_drv = '0;
        memReadValid = 1'b0; memReadData = '0;
        m_last = N - 1; m_lock_idx = -1; m_burst = 0;
        err_model = 1'b0; hold_data = '0;
        samp_en = 1'b0; samp_addr = '0; mismatch_prev = 1'b0;
        for (int s = 0; s < L; s++) begin
            mem_v[s] = 1'b0;
            mem_a[s] = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        mon_en  = 1'b1;
        chk_err = 1'b1;

        // Held in reset with all requesters asking: nothing may be granted.
        a = rand_addrs();
        step(1'b0, '1, a, '0, 1'b0);
        step(1'b0, '1, a, '0, 1'b0);

        // All requesters valid continuously: grants rotate 0,1,2,3,...
        for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(10'h100 + 10'h011 * i);
        for (int i = 0; i < 12; i++) step(1'b1, '1, a, '0, 1'b0);
        drain(L + 2);

        // Only requester 2 valid at 0x055: granted every cycle.
        a = rand_addrs();
        a[2*AW +: AW] = 10'h055;
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0100, a, '0, 1'b0);
        drain(L + 2);

        // Grants to 1 then 3 on consecutive cycles.
        a = rand_addrs();
        step(1'b1, 4'b0010, a, '0, 1'b0);
        step(1'b1, 4'b1000, a, '0, 1'b0);
        drain(L + 2);

        // Random traffic with randomly held lock requests.
        lk = '0;
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) lk = N'($urandom);
            step(1'b1, N'($urandom | $urandom), rand_addrs(), lk, 1'b0);
        end
        drain(L + 2);

        // Reset one cycle after two grants: in-flight reads vanish, 0 wins next.
        a = rand_addrs();
        step(1'b1, 4'b0110, a, '0, 1'b0);
        step(1'b1, 4'b0110, a, '0, 1'b0);
        step(1'b0, '1, a, '0, 1'b0);
        step(1'b1, '1, a, '0, 1'b0);
        drain(L + 3);

        // Burst lock on requester 0 against requester 1.
        a = rand_addrs();
        step(1'b0, '0, a, '0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 4'b0011, a, 4'b0001, 1'b0);
        drain(L + 2);
        step(1'b0, '0, a, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0011, a, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0011, a, 4'b0000, 1'b0);
        drain(L + 2);

        // Stray return with nothing outstanding: sticky error, no response.
        step(1'b1, '0, a, '0, 1'b1);
        drain(4);
        for (int i = 0; i < 4; i++) step(1'b1, '1, rand_addrs(), '0, 1'b0);
        drain(L + 3);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d unserved expected responses, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
